// File: rtl/wb_block_copier.sv
// wb_block_copier: Wishbone pipelined master that copies a block of words
// from src to dst on a single port, one read then one write per word.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready only when idle)
//   cmd_src_i/cmd_dst_i       first source / destination word address
//   cmd_len_i                 word count (0 = no bus activity)
//   busy_o                    high while a command is in progress
//   done_o                    one-cycle pulse at the end of a command
//   err_o                     pulses with done_o on an ack timeout
//   words_done_o              words written for the current/last command
//   wb_cyc_o .. wb_sel_o      Wishbone pipelined master request side
//   wb_stall_i, wb_ack_i      Wishbone stall / ack
//   wb_data_i                 read data, valid with wb_ack_i
//
// Optional feature: define WB_TIMEOUT_EN to abort a command when an ack
// does not arrive within TIMEOUT cycles (done_o and err_o pulse together).
module wb_block_copier #(
    parameter int AW      = 9,
    parameter int DW      = 32,
    parameter int LW      = 10,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [AW-1:0]   cmd_src_i,
    input  logic [AW-1:0]   cmd_dst_i,
    input  logic [LW-1:0]   cmd_len_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [LW-1:0]   words_done_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_data_o,
    output logic [DW/8-1:0] wb_sel_o,
    input  logic            wb_stall_i,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_data_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [LW-1:0] words_q, words_d;
    logic [DW-1:0] hold_q, hold_d;

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          tmo_hit;

    // Last allowed wait cycle without ack; the abort lands DONE exactly
    // TIMEOUT cycles after entering the wait state.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`else
    if (TIMEOUT < 1) begin : g_tmo_unused
    end
`endif

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        words_d     = words_q;
        hold_d      = hold_q;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        wb_we_o     = 1'b0;
        wb_addr_o   = '0;
        wb_data_o   = '0;
        wb_sel_o    = '0;
`ifdef WB_TIMEOUT_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    src_d   = cmd_src_i;
                    dst_d   = cmd_dst_i;
                    rem_d   = cmd_len_i;
                    words_d = '0;
`ifdef WB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = (cmd_len_i == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                wb_cyc_o  = 1'b1;
                wb_stb_o  = 1'b1;
                wb_addr_o = src_q;
                if (!wb_stall_i) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                wb_cyc_o = 1'b1;
                if (wb_ack_i) begin
                    hold_d  = wb_data_i;
                    state_d = S_WR_REQ;
                end
`ifdef WB_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_WR_REQ: begin
                wb_cyc_o  = 1'b1;
                wb_stb_o  = 1'b1;
                wb_we_o   = 1'b1;
                wb_sel_o  = '1;
                wb_addr_o = dst_q;
                wb_data_o = hold_q;
                if (!wb_stall_i) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                wb_cyc_o = 1'b1;
                if (wb_ack_i) begin
                    words_d = words_q + 1'b1;
                    src_d   = src_q + 1'b1;
                    dst_d   = dst_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == LW'(1)) ? S_DONE : S_RD_REQ;
                end
`ifdef WB_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            words_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            hold_q  <= hold_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    // Counter restarts on every state change and only runs while waiting.
    always_comb begin
        tmo_d = '0;
        if (state_d == state_q &&
            (state_q == S_RD_WAIT || state_q == S_WR_WAIT)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_o = done_o & err_q;
`else
    assign err_o = 1'b0;
`endif

    assign words_done_o = words_q;

endmodule
